// File: rtl/i2c_slave.sv
// I2C target with four 8-bit registers, reachable from the bus (auto-incrementing
// pointer) and from a local chip-select/write-strobe port.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       csn,
  input  logic [1:0] addr,
  input  logic       wrn,
  input  logic [7:0] d_in,
  output logic [7:0] d_out,
  output logic       busy,
  input  logic       i2c_scl,
  inout  wire        i2c_sda
);

  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, WR, WR_ACK, RD, RD_ACK} state_t;

  state_t     state;
  logic       scl_p0, scl_p1, scl_p2;
  logic       sda_p0, sda_p1, sda_p2;
  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [2:0] cnt;
  logic [7:0] sr;
  logic [7:0] rx_byte;
  logic [1:0] ptr;
  logic       rw, phase, first, sda_oe;
  logic [7:0] regs [4];

  assign i2c_sda = sda_oe ? 1'b0 : 1'bz;
  assign d_out   = regs[addr];
  assign rx_byte = {sr[6:0], sda_p1};

  // Stage p0/p1: synchronizers; p2: previous synchronized value for edge detection
  always_ff @(posedge clk) begin
    if (!clrn) begin
      scl_p0 <= 1'b1;
      scl_p1 <= 1'b1;
      scl_p2 <= 1'b1;
      sda_p0 <= 1'b1;
      sda_p1 <= 1'b1;
      sda_p2 <= 1'b1;
    end else begin
      scl_p0 <= i2c_scl;
      scl_p1 <= scl_p0;
      scl_p2 <= scl_p1;
      sda_p0 <= i2c_sda;
      sda_p1 <= sda_p0;
      sda_p2 <= sda_p1;
    end
  end

  assign scl_rise  = scl_p1 & ~scl_p2;
  assign scl_fall  = ~scl_p1 & scl_p2;
  assign start_det = scl_p1 & scl_p2 & sda_p2 & ~sda_p1;
  assign stop_det  = scl_p1 & scl_p2 & ~sda_p2 & sda_p1;

  // Protocol engine; `phase` marks the second half of an ACK slot or the end of a read byte
  always_ff @(posedge clk) begin
    if (!clrn) begin
      state  <= IDLE;
      cnt    <= 3'd0;
      sr     <= 8'h00;
      ptr    <= 2'd0;
      rw     <= 1'b0;
      phase  <= 1'b0;
      first  <= 1'b0;
      busy   <= 1'b0;
      sda_oe <= 1'b0;
      for (int i = 0; i < 4; i++) regs[i] <= 8'h00;
    end else begin
      if (!csn && !wrn) regs[addr] <= d_in;
      if (start_det) begin
        state  <= ADDR;
        cnt    <= 3'd0;
        phase  <= 1'b0;
        sda_oe <= 1'b0;
      end else if (stop_det) begin
        state  <= IDLE;
        cnt    <= 3'd0;
        phase  <= 1'b0;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin end
          ADDR: if (scl_rise) begin
            sr  <= rx_byte;
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              if (sr[6:0] == SLAVE_ADDR) begin
                state <= ADDR_ACK;
                busy  <= 1'b1;
                rw    <= sda_p1;
              end else begin
                state <= IDLE;
              end
            end
          end
          ADDR_ACK: if (scl_fall) begin
            if (!phase) begin
              phase  <= 1'b1;
              sda_oe <= 1'b1;
            end else begin
              phase <= 1'b0;
              if (rw) begin
                state  <= RD;
                sr     <= regs[ptr];
                ptr    <= ptr + 2'd1;
                sda_oe <= ~regs[ptr][7];
              end else begin
                state  <= WR;
                first  <= 1'b1;
                sda_oe <= 1'b0;
              end
            end
          end
          WR: if (scl_rise) begin
            sr  <= rx_byte;
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              state <= WR_ACK;
              if (first) begin
                ptr   <= rx_byte[1:0];
                first <= 1'b0;
              end else begin
                regs[ptr] <= rx_byte;
                ptr       <= ptr + 2'd1;
              end
            end
          end
          WR_ACK: if (scl_fall) begin
            if (!phase) begin
              phase  <= 1'b1;
              sda_oe <= 1'b1;
            end else begin
              phase  <= 1'b0;
              sda_oe <= 1'b0;
              state  <= WR;
            end
          end
          RD: begin
            if (scl_rise) begin
              cnt <= cnt + 3'd1;
              if (cnt == 3'd7) phase <= 1'b1;
            end else if (scl_fall) begin
              if (phase) begin
                phase  <= 1'b0;
                sda_oe <= 1'b0;
                state  <= RD_ACK;
              end else begin
                sr     <= {sr[6:0], 1'b0};
                sda_oe <= ~sr[6];
              end
            end
          end
          RD_ACK: begin
            if (scl_rise) begin
              if (sda_p1) begin
                state <= IDLE;
              end else begin
                sr    <= regs[ptr];
                ptr   <= ptr + 2'd1;
                phase <= 1'b1;
              end
            end else if (scl_fall && phase) begin
              phase  <= 1'b0;
              state  <= RD;
              sda_oe <= ~sr[7];
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/i2c_slave.md
I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h50, 7-bit bus address the block answers to.
REQ-002 SHALL have port clk  input  1  system clock, 50MHz.
REQ-003 SHALL have port clrn  input  1  reset; one clock, reset synchronous to clk and active-low.
REQ-004 SHALL have port csn  input  1  local chip select, active low.
REQ-005 SHALL have port addr  input  2  local register index 0..3.
REQ-006 SHALL have port wrn  input  1  local write strobe, active low, qualified by csn.
REQ-007 SHALL have port d_in  input  8  local write data.
REQ-008 SHALL have port d_out  output  8  regs[addr], combinational.
REQ-009 SHALL have port busy  output  1  high from addressed START until STOP or NACKed address.
REQ-010 SHALL have port i2c_scl  input  1  bus clock (no clock stretching).
REQ-011 SHALL have port i2c_sda  inout  1  open drain: 0 or z only.

Function
REQ-012 SHALL sample scl and sda through 2-flop synchronizers; all edge detection uses synchronized values.
REQ-013 SHALL detect START as sda falling while scl high, STOP as sda rising while scl high, in any state, including mid-byte.
REQ-014 SHALL use states IDLE, ADDR, ADDR_ACK, WR, WR_ACK, RD, RD_ACK.
REQ-015 SHALL go from any state to ADDR on START (repeated START included), clearing bit counter; STOP -> IDLE, release sda, busy=0.
REQ-016 SHALL shift sda MSB first on each synchronized scl rising edge; bit counter 0..7, wrap after 8th bit.
REQ-017 SHALL, in ADDR after 8 bits, compare bits[7:1] to SLAVE_ADDR: match -> ADDR_ACK, busy=1, R/W=bit0; mismatch -> IDLE, no sda drive.
REQ-018 SHALL drive ACK (sda=0) from the scl falling edge ending bit 8 until the next scl falling edge.
REQ-019 SHALL, after ADDR_ACK with R/W=0, enter WR; first received byte loads pointer ptr = byte[1:0] (bits [7:2] ignored).
REQ-020 SHALL write each subsequent WR byte to regs[ptr] then ptr = ptr+1 mod 4 (3 wraps to 0); ACK every byte.
REQ-021 SHALL, after ADDR_ACK with R/W=1, enter RD: load shift register with regs[ptr] at the ACK-ending scl falling edge, ptr = ptr+1 mod 4.
REQ-022 SHALL in RD change sda only after a synchronized scl falling edge: bit=0 -> drive 0, bit=1 -> release.
REQ-023 SHALL in RD_ACK release sda and sample master bit on scl rise: 0 (ACK) -> load next regs[ptr], increment, RD; 1 (NACK) -> IDLE with sda released, busy stays 1 until STOP.
REQ-024 SHALL write regs[addr]=d_in on clk when csn=0 and wrn=0; I2C register write to same index in same cycle wins.
REQ-025 SHALL keep ptr across transactions (repeated-START read continues from last pointer).

Reset
REQ-026 SHALL on clrn=0 at clk edge: state IDLE, regs all 8'h00, ptr 0, bit counter 0, busy 0, sda released (z); synchronizer flops set to 1.
REQ-027 SHALL, on reset mid-transfer, release sda in the cycle after the reset edge and ignore bus until next START.

Verification
REQ-028 SHALL pass: START, 8'hA0, 8'h01, 8'h5A, 8'hC3, STOP -> ACK on all 4 bytes; regs[1]=5A, regs[2]=C3, busy 0 after STOP.
REQ-029 SHALL pass: regs preloaded 11,22,33,44 via local port; START, 8'hA0, 8'h03, repeated START, 8'hA1, read 3 bytes ACK,ACK,NACK, STOP -> 44,11,22.
REQ-030 SHALL pass: START, 8'hA2 -> sda never driven low, busy 0, regs unchanged.
REQ-031 SHALL pass: STOP injected after 4 data bits of a write byte -> IDLE, target reg unchanged, sda released.
REQ-032 SHALL pass: local write regs[2]=8'h77 same cycle as I2C write regs[2]=8'h99 -> regs[2]=8'h99.
REQ-033 SHALL pass: clrn low during RD with sda driven 0 -> sda z next cycle, regs 00, d_out 00.
